// File: rtl/simd_alu_pkg.sv
// Shared definitions for the SIMD ALU datapath: vector and field widths,
// lane-mode codes, shift/rotate op codes and the mode/op legality check.
package simd_alu_pkg;

   localparam int SIMD_DATA_WIDTH            = 256;
   localparam int SIMD_ADDER_DATA_MODE_WIDTH = 3;
   localparam int SHIFT_OP_WIDTH             = 3;

   localparam logic [2:0] MODE_8   = 3'd0;
   localparam logic [2:0] MODE_16  = 3'd1;
   localparam logic [2:0] MODE_32  = 3'd2;
   localparam logic [2:0] MODE_64  = 3'd3;
   localparam logic [2:0] MODE_128 = 3'd4;

   typedef enum logic [2:0] {
      OP_SHL = 3'd0,
      OP_SHR = 3'd1,
      OP_SRA = 3'd2,
      OP_ROL = 3'd3,
      OP_ROR = 3'd4
   } shift_op_e;

   function automatic logic mode_op_legal(input logic [2:0] mode, input logic [2:0] op);
      return (mode <= MODE_128) && (op <= OP_ROR);
   endfunction

endpackage

// File: rtl/simd_shift_lane.sv
// Combinational single-lane shifter/rotator.
// Ports:
//   a  in  L   lane data
//   s  in  L   shift amount, full lane value (amounts >= L saturate shifts)
//   op in  3   shift_op_e code; unknown codes give 0
//   y  out L   lane result
module simd_shift_lane
   import simd_alu_pkg::*;
#(
   parameter int L = 8
) (
   input  logic [L-1:0]              a,
   input  logic [L-1:0]              s,
   input  logic [SHIFT_OP_WIDTH-1:0] op,
   output logic [L-1:0]              y
);

   localparam int          SW     = $clog2(L);
   localparam logic [L-1:0] LANE_W = L'(L);

   logic          big;
   logic [SW-1:0] sh;
   logic [L-1:0]  sh_ext;
   logic [L-1:0]  back;

   assign big    = (s >= LANE_W);
   // L is a power of two, so the low bits are both the in-range shift
   // amount and the rotate amount s mod L.
   assign sh     = s[SW-1:0];
   assign sh_ext = L'(sh);
   // For sh = 0 this is L, and shifting by the full width yields 0, so a
   // zero rotate returns the lane unchanged.
   assign back   = LANE_W - sh_ext;

   always_comb begin
      y = '0;
      case (op)
         OP_SHL:  y = big ? '0 : (a << sh);
         OP_SHR:  y = big ? '0 : (a >> sh);
         OP_SRA:  y = big ? {L{a[L-1]}} : L'($signed(a) >>> sh);
         OP_ROL:  y = (a << sh) | (a >> back);
         OP_ROR:  y = (a >> sh) | (a << back);
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/simd_alu_shifter_pipe.sv
// Two-stage valid/ready SIMD shifter/rotator. S1 registers the operands;
// S2 computes every lane width in parallel, picks the one matching
// data_mode and registers result/err.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid/in_ready    upstream handshake
//   a, b                 data vector and per-lane shift amounts
//   data_mode            0:8b 1:16b 2:32b 3:64b 4:128b lanes
//   op                   0:SHL 1:SHR 2:SRA 3:ROL 4:ROR
//   out_valid/out_ready  downstream handshake
//   result, err          lane-wise result; err flags illegal mode/op
module simd_alu_shifter_pipe
   import simd_alu_pkg::*;
#(
   parameter int SIMD_DATA_WIDTH            = simd_alu_pkg::SIMD_DATA_WIDTH,
   parameter int SIMD_ADDER_DATA_MODE_WIDTH = simd_alu_pkg::SIMD_ADDER_DATA_MODE_WIDTH,
   parameter int SHIFT_OP_WIDTH             = simd_alu_pkg::SHIFT_OP_WIDTH
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [SIMD_DATA_WIDTH-1:0]            a,
   input  logic [SIMD_DATA_WIDTH-1:0]            b,
   input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode,
   input  logic [SHIFT_OP_WIDTH-1:0]             op,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [SIMD_DATA_WIDTH-1:0]            result,
   output logic                                  err
);

   localparam int W = SIMD_DATA_WIDTH;

   logic                                  en1;
   logic                                  en2;
   logic                                  s1_valid;
   logic                                  s2_valid;
   logic [W-1:0]                          s1_a;
   logic [W-1:0]                          s1_b;
   logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] s1_mode;
   logic [SHIFT_OP_WIDTH-1:0]             s1_op;
   logic [4:0][W-1:0]                     mode_res;
   logic [W-1:0]                          s2_res_d;
   logic                                  s2_err_d;

   assign en2       = !s2_valid || out_ready;
   assign en1       = !s1_valid || en2;
   assign in_ready  = en1 && !rst;
   assign out_valid = s2_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_mode  <= '0;
         s1_op    <= '0;
      end else if (en1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a    <= a;
            s1_b    <= b;
            s1_mode <= data_mode;
            s1_op   <= op;
         end
      end
   end

   for (genvar m = 0; m < 5; m++) begin : g_mode
      localparam int LW = 8 << m;
      for (genvar i = 0; i < W / LW; i++) begin : g_lane
         simd_shift_lane #(.L(LW)) u_lane (
            .a  (s1_a[(i+1)*LW-1 -: LW]),
            .s  (s1_b[(i+1)*LW-1 -: LW]),
            .op (s1_op),
            .y  (mode_res[m][(i+1)*LW-1 -: LW])
         );
      end
   end

   always_comb begin
      s2_res_d = '0;
      s2_err_d = 1'b1;
      if (mode_op_legal(s1_mode, s1_op)) begin
         s2_err_d = 1'b0;
         case (s1_mode)
            MODE_8:   s2_res_d = mode_res[0];
            MODE_16:  s2_res_d = mode_res[1];
            MODE_32:  s2_res_d = mode_res[2];
            MODE_64:  s2_res_d = mode_res[3];
            MODE_128: s2_res_d = mode_res[4];
            default:  s2_res_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         result   <= '0;
         err      <= 1'b0;
      end else if (en2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            result <= s2_res_d;
            err    <= s2_err_d;
         end
      end
   end

endmodule

// File: tb/tb_simd_alu_shifter_pipe.sv
// Self-checking bench for simd_alu_shifter_pipe: directed corner cases,
// back-pressure, mid-stream reset and randomized traffic against a lane
// arithmetic reference model with an in-order scoreboard.
module tb_simd_alu_shifter_pipe;

   localparam int W = 256;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
      logic [W-1:0] cmask;
      logic [W-1:0] cval;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   data_mode = 3'd0;
   logic [2:0]   op = 3'd0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] result;
   logic         err;

   int           n_tests = 0;
   int           n_fail  = 0;
   exp_t         exp_q[$];
   logic         ov_s, ir_s, err_s, acc;
   logic [W-1:0] res_s;
   logic [W-1:0] dir_mask = '0;
   logic [W-1:0] dir_val  = '0;

   always #5 clk = ~clk;

   simd_alu_shifter_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .data_mode (data_mode),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   function automatic logic [W-1:0] ref_shift(input logic [W-1:0] va, input logic [W-1:0] vb,
                                              input int mode, input int opc, output logic e);
      logic [W-1:0] acc_v;
      logic [127:0] mask, x, s, y, r, fill;
      int           L;
      logic         msb;
      acc_v = '0;
      if (mode > 4 || opc > 4) begin
         e = 1'b1;
         return acc_v;
      end
      e    = 1'b0;
      L    = 8 << mode;
      mask = {128{1'b1}} >> (128 - L);
      for (int i = 0; i < W / L; i++) begin
         x   = 128'(va >> (i * L)) & mask;
         s   = 128'(vb >> (i * L)) & mask;
         msb = x[L-1];
         r   = s % L;
         y   = '0;
         case (opc)
            0: y = (s >= L) ? '0 : ((x << s) & mask);
            1: y = (s >= L) ? '0 : (x >> s);
            2: begin
               if (s >= L) y = msb ? mask : '0;
               else begin
                  fill = mask & ~(mask >> s);
                  y    = (x >> s) | (msb ? fill : '0);
               end
            end
            3: y = (r == 0) ? x : (((x << r) | (x >> (L - r))) & mask);
            default: y = (r == 0) ? x : (((x >> r) | (x << (L - r))) & mask);
         endcase
         acc_v = acc_v | (W'(y) << (i * L));
      end
      return acc_v;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W / 32; i++) v = (v << 32) | W'($urandom);
      return v;
   endfunction

   function automatic logic [W-1:0] rand_amounts(input int mode);
      logic [W-1:0] v;
      logic [127:0] lv, mask;
      int           L;
      v    = '0;
      L    = (mode <= 4) ? (8 << mode) : 8;
      mask = {128{1'b1}} >> (128 - L);
      for (int i = 0; i < W / L; i++) begin
         if ($urandom % 4 == 0) lv = 128'(rand_vec()) & mask;
         else lv = 128'($urandom_range(0, 2 * L));
         v = v | (W'(lv) << (i * L));
      end
      return v;
   endfunction

   task automatic tick(input logic vin, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic [2:0] vm, input logic [2:0] vo, input logic ordy, input logic vrst);
      exp_t e;
      logic ee;
      @(negedge clk);
      in_valid  = vin;
      a         = va;
      b         = vb;
      data_mode = vm;
      op        = vo;
      out_ready = ordy;
      rst       = vrst;
      #1;
      ov_s  = out_valid;
      ir_s  = in_ready;
      res_s = result;
      err_s = err;
      acc   = vin & in_ready;
      if (!vrst && out_valid && ordy) begin
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL stale_emit: observed out_valid=1 with result %h, expected no pending op", res_s);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_tests++;
            assert (res_s === e.res) else begin
               n_fail++;
               $error("FAIL result: observed %h expected %h", res_s, e.res);
            end
            n_tests++;
            assert (err_s === e.err) else begin
               n_fail++;
               $error("FAIL err: observed %b expected %b", err_s, e.err);
            end
            if (e.cmask != '0) begin
               n_tests++;
               assert ((res_s & e.cmask) === e.cval) else begin
                  n_fail++;
                  $error("FAIL directed: observed %h expected %h", res_s & e.cmask, e.cval);
               end
            end
         end
      end
      if (acc) begin
         e.res   = ref_shift(va, vb, int'(vm), int'(vo), ee);
         e.err   = ee;
         e.cmask = dir_mask;
         e.cval  = dir_val;
         exp_q.push_back(e);
      end
      @(posedge clk);
   endtask

   task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vm, input logic [2:0] vo);
      int n = 0;
      do begin
         tick(1'b1, va, vb, vm, vo, 1'b1, 1'b0);
         n++;
      end while (!acc && n < 50);
      n_tests++;
      assert (acc) else begin
         n_fail++;
         $error("FAIL send_timeout: observed accepted=%b expected 1", acc);
      end
      dir_mask = '0;
      dir_val  = '0;
   endtask

   task automatic idle(input logic ordy);
      tick(1'b0, '0, '0, 3'd0, 3'd0, ordy, 1'b0);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || ov_s) && n < 40) begin
         idle(1'b1);
         n++;
      end
      n_tests++;
      assert (exp_q.size() == 0) else begin
         n_fail++;
         $error("FAIL drain: observed %0d pending ops expected 0", exp_q.size());
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   initial begin
      logic [W-1:0] va, vb, hold;
      logic [W-1:0] oa[5], ob[5];
      logic [2:0]   om[5], oo[5];
      int           idx;
      logic [2:0]   rm, ro;

      // reset
      tick(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b1);
      tick(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b1);
      check_bit("rst_in_ready", ir_s, 1'b0);
      idle(1'b1);
      check_bit("rst_out_valid", ov_s, 1'b0);
      check_bit("rst_err", err_s, 1'b0);
      n_tests++;
      assert (res_s === '0) else begin
         n_fail++;
         $error("FAIL rst_result: observed %h expected 0", res_s);
      end
      check_bit("post_rst_in_ready", ir_s, 1'b1);

      // 8-bit lanes
      va = rand_vec(); va[7:0] = 8'h81; vb = '0; vb[7:0] = 8'h01;
      dir_mask = '1; dir_val = {va[W-1:8], 8'h02};
      send(va, vb, 3'd0, 3'd0);
      va = rand_vec(); va[7:0] = 8'h81; vb = '0; vb[7:0] = 8'h08;
      dir_mask = '1; dir_val = {va[W-1:8], 8'h00};
      send(va, vb, 3'd0, 3'd1);

      // 16-bit SRA
      va = rand_vec(); va[15:0] = 16'h8000; vb = '0; vb[15:0] = 16'd4;
      dir_mask = '1; dir_val = {va[W-1:16], 16'hF800};
      send(va, vb, 3'd1, 3'd2);
      va = rand_vec(); va[15:0] = 16'h8000; vb = '0; vb[15:0] = 16'h00FF;
      dir_mask = '1; dir_val = {va[W-1:16], 16'hFFFF};
      send(va, vb, 3'd1, 3'd2);
      va = rand_vec(); va[15:0] = 16'h7000; vb = '0; vb[15:0] = 16'h00FF;
      dir_mask = '1; dir_val = {va[W-1:16], 16'h0000};
      send(va, vb, 3'd1, 3'd2);

      // 32-bit rotates
      va = rand_vec(); va[31:0] = 32'h1; vb = '0; vb[31:0] = 32'd1;
      dir_mask = '1; dir_val = {va[W-1:32], 32'h80000000};
      send(va, vb, 3'd2, 3'd4);
      va = rand_vec(); va[31:0] = 32'h1; vb = '0; vb[31:0] = 32'd33;
      dir_mask = '1; dir_val = {va[W-1:32], 32'h80000000};
      send(va, vb, 3'd2, 3'd4);
      va = rand_vec(); va[31:0] = 32'h1; vb = '0; vb[31:0] = 32'd32;
      dir_mask = '1; dir_val = {va[W-1:32], 32'h00000001};
      send(va, vb, 3'd2, 3'd3);

      // 128-bit SHL to the top bit
      va = rand_vec(); va[127:0] = 128'd1; vb = '0; vb[127:0] = 128'd127;
      dir_mask = '1; dir_val = {va[W-1:128], 1'b1, 127'd0};
      send(va, vb, 3'd4, 3'd0);
      drain();

      // illegal mode/op with latency check on an empty pipe
      dir_mask = '1; dir_val = '0;
      send(rand_vec(), rand_vec(), 3'd5, 3'd0);
      idle(1'b1);
      check_bit("lat_mode5_n1", ov_s, 1'b0);
      idle(1'b1);
      check_bit("lat_mode5_n2", ov_s, 1'b1);
      drain();
      dir_mask = '1; dir_val = '0;
      send(rand_vec(), rand_vec(), 3'd0, 3'd6);
      idle(1'b1);
      check_bit("lat_op6_n1", ov_s, 1'b0);
      idle(1'b1);
      check_bit("lat_op6_n2", ov_s, 1'b1);
      drain();

      // back-pressure: 5 ops, out_ready low for the first 4 cycles
      for (int i = 0; i < 5; i++) begin
         om[i] = 3'($urandom_range(0, 4));
         oo[i] = 3'($urandom_range(0, 4));
         oa[i] = rand_vec();
         ob[i] = rand_amounts(int'(om[i]));
      end
      idx  = 0;
      hold = '0;
      for (int cyc = 0; cyc < 40 && (idx < 5 || exp_q.size() != 0); cyc++) begin
         if (idx < 5) tick(1'b1, oa[idx], ob[idx], om[idx], oo[idx], cyc >= 4, 1'b0);
         else tick(1'b0, '0, '0, 3'd0, 3'd0, 1'b1, 1'b0);
         if (acc) idx++;
         if (cyc == 1) begin
            n_tests++;
            assert (idx == 2) else begin
               n_fail++;
               $error("FAIL bp_accepts: observed %0d expected 2", idx);
            end
         end
         if (cyc == 2) begin
            check_bit("bp_in_ready_c2", ir_s, 1'b0);
            check_bit("bp_out_valid_c2", ov_s, 1'b1);
            hold = res_s;
         end
         if (cyc == 3) begin
            check_bit("bp_in_ready_c3", ir_s, 1'b0);
            n_tests++;
            assert (res_s === hold) else begin
               n_fail++;
               $error("FAIL bp_hold: observed %h expected %h", res_s, hold);
            end
         end
      end
      drain();

      // reset with two ops in flight
      tick(1'b1, rand_vec(), rand_vec(), 3'd0, 3'd0, 1'b0, 1'b0);
      tick(1'b1, rand_vec(), rand_vec(), 3'd1, 3'd1, 1'b0, 1'b0);
      n_tests++;
      assert (exp_q.size() == 2) else begin
         n_fail++;
         $error("FAIL mid_rst_inflight: observed %0d expected 2", exp_q.size());
      end
      tick(1'b0, '0, '0, 3'd0, 3'd0, 1'b0, 1'b1);
      check_bit("mid_rst_in_ready", ir_s, 1'b0);
      exp_q.delete();
      idle(1'b1);
      check_bit("mid_rst_out_valid", ov_s, 1'b0);
      n_tests++;
      assert (res_s === '0) else begin
         n_fail++;
         $error("FAIL mid_rst_result: observed %h expected 0", res_s);
      end
      for (int i = 0; i < 5; i++) idle(1'b1);
      check_bit("mid_rst_no_stale", ov_s, 1'b0);

      // randomized traffic with random stalls
      for (int i = 0; i < 400; i++) begin
         rm = ($urandom % 12 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         ro = ($urandom % 12 == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         tick(($urandom % 4) != 0, rand_vec(), rand_amounts(int'(rm)), rm, ro, ($urandom % 3) != 0, 1'b0);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
